// File: rtl/mem_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_pkg : address map, buffer depth and FSM encoding for mem_access_unit    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_pkg;
   localparam int FB_BASE_BIT   = 15;
   localparam int RAM_AW        = 8;
   localparam int FB_AW         = 15;
   localparam int DATA_W        = 16;
   localparam int FB_FIFO_DEPTH = 4;
   localparam int FB_LVL_W      = 3;

   typedef logic [0:0] state_t;
   localparam state_t IDLE    = 1'b0;
   localparam state_t RD_WAIT = 1'b1;

   typedef struct packed {
      logic [FB_AW-1:0]  addr;
      logic [DATA_W-1:0] data;
   } fb_wr_t;
endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// +----------------------------------------------------------------------------+
// | mem_access_unit_if : pipeline request, data RAM and framebuffer signals     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mem_access_unit_if;
   import mem_pkg::*;

   logic                req_valid;
   logic                req_we;
   logic [15:0]         req_addr;
   logic [DATA_W-1:0]   req_wdata;
   logic                stall;
   logic [DATA_W-1:0]   rdata;
   logic                rdata_valid;
   logic [RAM_AW-1:0]   ram_addr;
   logic [DATA_W-1:0]   ram_wdata;
   logic                ram_wren;
   logic [DATA_W-1:0]   ram_q;
   logic                fb_wr_valid;
   logic                fb_wr_ready;
   logic [FB_AW-1:0]    fb_wr_addr;
   logic [DATA_W-1:0]   fb_wr_data;
   logic [FB_LVL_W-1:0] fb_level;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, ram_q, fb_wr_ready,
      output stall, rdata, rdata_valid, ram_addr, ram_wdata, ram_wren,
             fb_wr_valid, fb_wr_addr, fb_wr_data, fb_level
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, ram_q, fb_wr_ready,
      input  stall, rdata, rdata_valid, ram_addr, ram_wdata, ram_wren,
             fb_wr_valid, fb_wr_addr, fb_wr_data, fb_level
   );
endinterface

`default_nettype wire

// File: rtl/fb_wr_fifo.sv
// +----------------------------------------------------------------------------+
// | fb_wr_fifo : small write buffer of {pixel address, data} ahead of the VGA   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module fb_wr_fifo
   import mem_pkg::*;
(
   input  wire logic                clk,
   input  wire logic                rst,
   input  wire logic                push_i,
   input  wire logic                pop_i,
   input  wire fb_wr_t              din_i,
   output      fb_wr_t              dout_o,
   output      logic                full_o,
   output      logic                empty_o,
   output      logic [FB_LVL_W-1:0] level_o
);
   localparam int PTR_W = $clog2(FB_FIFO_DEPTH);

   fb_wr_t              mem_q [FB_FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [FB_LVL_W-1:0] level_q;
   logic                do_push;
   logic                do_pop;

   assign full_o  = (level_q == FB_LVL_W'(FB_FIFO_DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign dout_o  = mem_q[rd_ptr_q];

   // A push into a full buffer is legal when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end
endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +----------------------------------------------------------------------------+
// | mem_access_unit : memory-stage decode to data RAM or framebuffer writes.   |
// | FB_WRITE_BUFFER_EN adds a 4-entry framebuffer write FIFO.                  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
   import mem_pkg::*;
(
   input wire logic          clk,
   input wire logic          rst,
   mem_access_unit_if.slave  bus
);
   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;
   logic              rd_valid;
   logic              idle;
   logic              is_fb;
   logic              ram_st;
   logic              ram_ld;
   logic              fb_st;
   logic              fb_ld;
   logic              fb_stall;

   // While a RAM load completes the held request is the same load, so ignore it.
   assign idle   = (state_q == IDLE);
   assign is_fb  = bus.req_addr[FB_BASE_BIT];
   assign ram_st = idle && bus.req_valid && !is_fb &&  bus.req_we;
   assign ram_ld = idle && bus.req_valid && !is_fb && !bus.req_we;
   assign fb_st  = idle && bus.req_valid &&  is_fb &&  bus.req_we;
   assign fb_ld  = idle && bus.req_valid &&  is_fb && !bus.req_we;

   always_comb begin
      state_d  = state_q;
      rdata_d  = rdata_q;
      rd_valid = 1'b0;
      if (state_q == RD_WAIT) begin
         rd_valid = 1'b1;
         rdata_d  = bus.ram_q;
         state_d  = IDLE;
      end else if (ram_ld) begin
         state_d  = RD_WAIT;
      end else if (fb_ld) begin
         rd_valid = 1'b1;
         rdata_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.rdata       = rdata_d;
   assign bus.rdata_valid = rst && rd_valid;
   assign bus.stall       = rst && (ram_ld || fb_stall);
   assign bus.ram_addr    = bus.req_addr[RAM_AW-1:0];
   assign bus.ram_wdata   = bus.req_wdata;
   assign bus.ram_wren    = rst && ram_st;

`ifdef FB_WRITE_BUFFER_EN
   fb_wr_t              fifo_din;
   fb_wr_t              fifo_head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_pop;
   logic [FB_LVL_W-1:0] fifo_level;

   assign fifo_din = '{addr: bus.req_addr[FB_AW-1:0], data: bus.req_wdata};
   assign fifo_pop = !fifo_empty && bus.fb_wr_ready;
   assign fb_stall = fb_st && fifo_full && !fifo_pop;

   fb_wr_fifo u_fb_wr_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fb_st),
      .pop_i   (fifo_pop),
      .din_i   (fifo_din),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign bus.fb_wr_valid = !fifo_empty;
   assign bus.fb_wr_addr  = fifo_head.addr;
   assign bus.fb_wr_data  = fifo_head.data;
   assign bus.fb_level    = fifo_level;
`else
   assign fb_stall        = fb_st && !bus.fb_wr_ready;
   assign bus.fb_wr_valid = rst && fb_st;
   assign bus.fb_wr_addr  = bus.req_addr[FB_AW-1:0];
   assign bus.fb_wr_data  = bus.req_wdata;
   assign bus.fb_level    = '0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +----------------------------------------------------------------------------+
// | tb_mem_access_unit : directed self-checking bench for mem_access_unit       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_unit;
   logic        clk;
   logic        rst;
   int          n_checks;
   int          n_errors;
   logic [15:0] ram_mem [256];

   mem_access_unit_if bus_if ();

   mem_access_unit u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data RAM with registered read, one cycle of latency.
   always @(posedge clk) begin
      if (bus_if.ram_wren) ram_mem[bus_if.ram_addr] <= bus_if.ram_wdata;
      bus_if.ram_q <= ram_mem[bus_if.ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic v, input logic we, input logic [15:0] a,
                          input logic [15:0] d, input logic rdy);
      bus_if.req_valid   = v;
      bus_if.req_we      = we;
      bus_if.req_addr    = a;
      bus_if.req_wdata   = d;
      bus_if.fb_wr_ready = rdy;
   endtask

   task automatic drive(input logic v, input logic we, input logic [15:0] a,
                        input logic [15:0] d, input logic rdy);
      @(negedge clk);
      set_req(v, we, a, d, rdy);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      set_req(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      check("rst_stall",    32'(bus_if.stall),       32'd0);
      check("rst_rdata",    32'(bus_if.rdata),       32'd0);
      check("rst_rvalid",   32'(bus_if.rdata_valid), 32'd0);
      check("rst_wren",     32'(bus_if.ram_wren),    32'd0);
      check("rst_fbvalid",  32'(bus_if.fb_wr_valid), 32'd0);
      check("rst_fblevel",  32'(bus_if.fb_level),    32'd0);
      @(negedge clk);
      rst = 1'b1;

      // RAM store then load of the same word
      drive(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
      check("st_wren",   32'(bus_if.ram_wren),    32'd1);
      check("st_addr",   32'(bus_if.ram_addr),    32'h10);
      check("st_wdata",  32'(bus_if.ram_wdata),   32'hBEEF);
      check("st_stall",  32'(bus_if.stall),       32'd0);
      check("st_rvalid", 32'(bus_if.rdata_valid), 32'd0);
      drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
      check("ld_stall",  32'(bus_if.stall),       32'd1);
      check("ld_rvalid", 32'(bus_if.rdata_valid), 32'd0);
      check("ld_wren",   32'(bus_if.ram_wren),    32'd0);
      drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
      check("rw_stall",  32'(bus_if.stall),       32'd0);
      check("rw_rvalid", 32'(bus_if.rdata_valid), 32'd1);
      check("rw_rdata",  32'(bus_if.rdata),       32'hBEEF);
      check("rw_wren",   32'(bus_if.ram_wren),    32'd0);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      check("hold_rvalid", 32'(bus_if.rdata_valid), 32'd0);
      check("hold_rdata",  32'(bus_if.rdata),       32'hBEEF);
      drive(1'b1, 1'b1, 16'h7F23, 16'h5A5A, 1'b0);
      check("st2_addr", 32'(bus_if.ram_addr), 32'h23);
      check("st2_wren", 32'(bus_if.ram_wren), 32'd1);

      // Framebuffer load returns zero immediately
      drive(1'b1, 1'b0, 16'h9234, 16'h0000, 1'b0);
      check("fbld_rdata",  32'(bus_if.rdata),       32'h0000);
      check("fbld_rvalid", 32'(bus_if.rdata_valid), 32'd1);
      check("fbld_stall",  32'(bus_if.stall),       32'd0);
      check("fbld_fbv",    32'(bus_if.fb_wr_valid), 32'd0);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      check("fbld_after", 32'(bus_if.rdata_valid), 32'd0);
      check("fbld_hold",  32'(bus_if.rdata),       32'h0000);

`ifdef FB_WRITE_BUFFER_EN
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 16'h8000 + 16'(i), 16'hA000 + 16'(i), 1'b0);
         check("fill_stall", 32'(bus_if.stall),    32'd0);
         check("fill_level", 32'(bus_if.fb_level), 32'(i));
      end
      drive(1'b1, 1'b1, 16'h8004, 16'hA004, 1'b0);
      check("full_level", 32'(bus_if.fb_level),    32'd4);
      check("full_stall", 32'(bus_if.stall),       32'd1);
      check("full_fbv",   32'(bus_if.fb_wr_valid), 32'd1);
      drive(1'b1, 1'b1, 16'h8004, 16'hA004, 1'b0);
      check("retry_stall", 32'(bus_if.stall), 32'd1);
      drive(1'b1, 1'b1, 16'h8004, 16'hA004, 1'b1);
      check("pp_stall", 32'(bus_if.stall),      32'd0);
      check("pp_addr",  32'(bus_if.fb_wr_addr), 32'h0000);
      check("pp_data",  32'(bus_if.fb_wr_data), 32'hA000);
      drive(1'b1, 1'b1, 16'h8005, 16'hA005, 1'b1);
      check("pp2_level", 32'(bus_if.fb_level),   32'd4);
      check("pp2_stall", 32'(bus_if.stall),      32'd0);
      check("pp2_addr",  32'(bus_if.fb_wr_addr), 32'h0001);
      check("pp2_data",  32'(bus_if.fb_wr_data), 32'hA001);
      for (int k = 2; k < 6; k++) begin
         drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
         check("drain_level", 32'(bus_if.fb_level),   32'(6 - k));
         check("drain_addr",  32'(bus_if.fb_wr_addr), 32'(k));
         check("drain_data",  32'(bus_if.fb_wr_data), 32'hA000 + 32'(k));
      end
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      check("empty_fbv",   32'(bus_if.fb_wr_valid), 32'd0);
      check("empty_level", 32'(bus_if.fb_level),    32'd0);
`else
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 1'b1, 16'h8001, 16'h1234, 1'b0);
         check("direct_stall", 32'(bus_if.stall),       32'd1);
         check("direct_fbv",   32'(bus_if.fb_wr_valid), 32'd1);
      end
      check("direct_addr", 32'(bus_if.fb_wr_addr), 32'h0001);
      check("direct_data", 32'(bus_if.fb_wr_data), 32'h1234);
      drive(1'b1, 1'b1, 16'h8001, 16'h1234, 1'b1);
      check("direct_done",  32'(bus_if.stall),       32'd0);
      check("direct_fbv4",  32'(bus_if.fb_wr_valid), 32'd1);
      check("direct_level", 32'(bus_if.fb_level),    32'd0);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      check("direct_idle", 32'(bus_if.fb_wr_valid), 32'd0);
`endif

      // Reset while a load is in RD_WAIT (and with buffered writes pending)
`ifdef FB_WRITE_BUFFER_EN
      drive(1'b1, 1'b1, 16'h8010, 16'hC000, 1'b0);
      drive(1'b1, 1'b1, 16'h8011, 16'hC001, 1'b0);
`endif
      drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
      check("pre_rst_stall", 32'(bus_if.stall), 32'd1);
`ifdef FB_WRITE_BUFFER_EN
      check("pre_rst_level", 32'(bus_if.fb_level), 32'd2);
`endif
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_stall",  32'(bus_if.stall),       32'd0);
      check("arst_rvalid", 32'(bus_if.rdata_valid), 32'd0);
      check("arst_rdata",  32'(bus_if.rdata),       32'd0);
      check("arst_wren",   32'(bus_if.ram_wren),    32'd0);
      check("arst_fbv",    32'(bus_if.fb_wr_valid), 32'd0);
      check("arst_level",  32'(bus_if.fb_level),    32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      set_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
      #1;
      check("post_stall",  32'(bus_if.stall),       32'd1);
      check("post_rvalid", 32'(bus_if.rdata_valid), 32'd0);
      check("post_fbv",    32'(bus_if.fb_wr_valid), 32'd0);
      drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
      check("post_rdata",  32'(bus_if.rdata),       32'hBEEF);
      check("post_rv2",    32'(bus_if.rdata_valid), 32'd1);
      check("post_fbv2",   32'(bus_if.fb_wr_valid), 32'd0);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      check("post_fbv3",   32'(bus_if.fb_wr_valid), 32'd0);
      check("post_level",  32'(bus_if.fb_level),    32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

`default_nettype wire
